// File: rtl/seq_restoring_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock,
// MSB first, with a start/busy/done handshake and a single-edge
// divide-by-zero path.
module seq_restoring_divider #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             dbz
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH:0]     prem_q, prem_d;
  logic [WIDTH-1:0]   quo_sh_q, quo_sh_d;
  logic [WIDTH-1:0]   dvd_q, dvd_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic [WIDTH-1:0]   quotient_q, quotient_d;
  logic [WIDTH-1:0]   remainder_q, remainder_d;
  logic               dbz_q, dbz_d;
  logic [WIDTH+1:0]   step;

  // One restoring iteration: shift in the next dividend bit, trial-subtract
  // the zero-extended divisor, keep or restore. Returns {quotient_bit, prem}.
  // The kept partial remainder is always < divisor, so the shifted value
  // fits in WIDTH+1 bits and bit WIDTH of the difference is its sign.
  function automatic logic [WIDTH+1:0] div_step(input logic [WIDTH:0]   prem,
                                                input logic             in_bit,
                                                input logic [WIDTH-1:0] dvs);
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;
    shifted = (prem << 1) | {{WIDTH{1'b0}}, in_bit};
    trial   = shifted - {1'b0, dvs};
    if (trial[WIDTH]) return {1'b0, shifted};
    else              return {1'b1, trial};
  endfunction

  // Next-state, datapath and result update for the IDLE/RUN/DONE sequencer.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    prem_d      = prem_q;
    quo_sh_d    = quo_sh_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    step        = div_step(prem_q, dvd_q[WIDTH-1], dvs_q);

    case (state_q)
      S_IDLE, S_DONE: begin
        // DONE returns to IDLE unless a back-to-back start is accepted.
        state_d = S_IDLE;
        if (start) begin
          if (divisor != '0) begin
            dvd_d    = dividend;
            dvs_d    = divisor;
            prem_d   = '0;
            quo_sh_d = '0;
            cnt_d    = CNT_W'(WIDTH - 1);
            state_d  = S_RUN;
          end else begin
            // Divide by zero resolves on this single edge.
            dbz_d       = 1'b1;
            quotient_d  = '1;
            remainder_d = dividend;
            state_d     = S_DONE;
          end
        end
      end
      S_RUN: begin
        prem_d   = step[WIDTH:0];
        quo_sh_d = {quo_sh_q[WIDTH-2:0], step[WIDTH+1]};
        dvd_d    = {dvd_q[WIDTH-2:0], 1'b0};
        if (cnt_q == '0) begin
          quotient_d  = {quo_sh_q[WIDTH-2:0], step[WIDTH+1]};
          remainder_d = step[WIDTH-1:0];
          dbz_d       = 1'b0;
          state_d     = S_DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control state and visible results; reset clears them.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  // Working datapath registers; only meaningful while RUN, so left unreset.
  always_ff @(posedge clk) begin
    prem_q   <= prem_d;
    quo_sh_q <= quo_sh_d;
    dvd_q    <= dvd_d;
    dvs_q    <= dvs_d;
  end

  assign busy      = (state_q == S_RUN);
  assign done      = (state_q == S_DONE);
  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign dbz       = dbz_q;

endmodule
